// File: rtl/fsmc_fifo_reg.sv
// Register-mapped loopback FIFO slave on the FSMC user side: data-port writes push,
// data-port reads pop (show-ahead), and a status/control port reports level and flags.
module fsmc_fifo_reg #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        sel,
  input  logic        state,
  input  logic [15:0] rd_data,
  output logic [15:0] wr_data,
  output logic        empty,
  output logic        full
);

  // Handshake: en is a one-clk strobe per completed bus access with no back-pressure;
  // sel/state/rd_data are only meaningful while en=1, and wr_data is always valid.

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_unf;

  logic          w_data_wr;
  logic          w_data_rd;
  logic          w_stat_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_clear;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [10:0]   w_cnt_ext;
  logic [15:0]   w_status;
  logic [15:0]   w_head;

  assign empty = (r_cnt == CW'(0));
  assign full  = (r_cnt == CW'(DEPTH));

  assign w_data_wr = en & ~sel & ~state;
  assign w_data_rd = en & ~sel &  state;
  assign w_stat_wr = en &  sel & ~state;

  assign w_push    = w_data_wr & ~full;
  assign w_pop     = w_data_rd & ~empty;
  assign w_ovf_set = w_data_wr &  full;
  assign w_unf_set = w_data_rd &  empty;
  assign w_flush   = w_stat_wr & rd_data[0];
  assign w_clear   = w_stat_wr & rd_data[1];

  // Storage is deliberately left out of reset; only pointers, count and flags reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_wp  <= r_wp + AW'(1);
      r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_rp  <= r_rp + AW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Set and clear never coincide: sets come from the data port, clears from status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  assign w_cnt_ext = 11'(r_cnt);
  assign w_status  = {r_ovf, r_unf, full, empty, 1'b0, w_cnt_ext};
  assign w_head    = empty ? 16'h0000 : r_mem[r_rp];
  assign wr_data   = sel ? w_status : w_head;

endmodule

// File: tb/tb_fsmc_fifo_reg.sv
// Directed bench for fsmc_fifo_reg: reset, ordering, overflow/underflow, wrap,
// flush/clear and asynchronous reset, checked against hand-computed values.
module tb_fsmc_fifo_reg;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        sel;
  logic        state;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic        empty;
  logic        full;

  int n_checks;
  int n_fail;
  logic [15:0] exp_q[$];

  fsmc_fifo_reg #(.DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .sel     (sel),
    .state   (state),
    .rd_data (rd_data),
    .wr_data (wr_data),
    .empty   (empty),
    .full    (full)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks: each access raises en for exactly one rising edge.
  task automatic bus_write(input logic s, input logic [15:0] d);
    en = 1'b1; sel = s; state = 1'b0; rd_data = d;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic bus_read(input logic s, output logic [15:0] d);
    en = 1'b1; sel = s; state = 1'b1;
    #2 d = wr_data;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic stat_check(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(1'b1, v);
    check(tag, v, exp);
  endtask

  task automatic push_model(input logic [15:0] d);
    bus_write(1'b0, d);
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] v;
    logic [15:0] e;
    e = exp_q.pop_front();
    bus_read(1'b0, v);
    check(tag, v, e);
  endtask

  initial begin
    logic [15:0] v;
    n_checks = 0;
    n_fail   = 0;
    en = 1'b0; sel = 1'b0; state = 1'b0; rd_data = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_empty", {15'd0, empty}, 16'd1);
    check("reset_full", {15'd0, full}, 16'd0);
    sel = 1'b1; #1;
    check("reset_status_comb", wr_data, 16'h1000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and underflow
    stat_check("status_after_reset", 16'h1000);
    bus_read(1'b0, v);
    check("read_empty_data", v, 16'h0000);
    stat_check("status_unf", 16'h5000);
    bus_write(1'b1, 16'h0002);
    stat_check("status_cleared", 16'h1000);

    // Idle cycles with en=0 must not change anything
    sel = 1'b0; state = 1'b0; rd_data = 16'hDEAD;
    repeat (2) @(posedge clk); #1;
    stat_check("idle_no_change", 16'h1000);

    // Basic order, back-to-back writes
    push_model(16'hA5A5);
    push_model(16'h1234);
    push_model(16'hFFFF);
    stat_check("status_three", 16'h0003);
    pop_check("order_0");
    pop_check("order_1");
    pop_check("order_2");
    stat_check("status_drained", 16'h1000);

    // Overflow: 17th word dropped
    for (int i = 0; i < 17; i++) begin
      bus_write(1'b0, 16'(i));
      if (i < 16) exp_q.push_back(16'(i));
    end
    stat_check("status_ovf_full", 16'hA010);
    check("full_pin", {15'd0, full}, 16'd1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_read_%0d", i));
    stat_check("status_after_ovf_drain", 16'h9000);
    bus_write(1'b1, 16'h0002);
    stat_check("status_ovf_cleared", 16'h1000);

    // Wrap-around: 40 x (3 writes, 3 reads)
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 3; j++) push_model(16'(k * 3 + j + 16'h0100));
      for (int j = 0; j < 3; j++) pop_check($sformatf("wrap_%0d_%0d", k, j));
    end
    stat_check("status_after_wrap", 16'h1000);

    // Underflow, 5 writes, then flush+clear in one status write
    bus_read(1'b0, v);
    check("unf_before_flush", v, 16'h0000);
    for (int i = 0; i < 5; i++) bus_write(1'b0, 16'(16'h0050 + i));
    stat_check("status_five_unf", 16'h4005);
    bus_write(1'b1, 16'h0003);
    stat_check("status_after_flush", 16'h1000);
    bus_read(1'b0, v);
    check("data_after_flush", v, 16'h0000);
    bus_write(1'b1, 16'h0002);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) bus_write(1'b0, 16'(16'h0070 + i));
    stat_check("status_four", 16'h0004);
    @(posedge clk); #3;
    sel = 1'b1; state = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_empty", {15'd0, empty}, 16'd1);
    check("async_status", wr_data, 16'h1000);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_write(1'b0, 16'hBEEF);
    stat_check("status_post_reset_push", 16'h0001);
    bus_read(1'b0, v);
    check("data_post_reset", v, 16'hBEEF);
    stat_check("status_post_reset_final", 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsmc_fifo_reg.md
# fsmc_fifo_reg

Register-mapped loopback FIFO slave on the FSMC user-side interface. It sits directly downstream of `fsmc_interface` alongside `test_reg`, and is enabled by a chip-select bit (cs[1] at top level). MCU write accesses to the data port push 16-bit words into an internal FIFO; MCU read accesses pop them back. A status/control port exposes the FIFO level and sticky error flags, and accepts flush and clear commands.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, 2..1024.
- CW, $clog2(DEPTH)+1, count width; derived, not overridden.

- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  access strobe from `fsmc_interface` chip select; high for exactly one clk per completed bus access.
- sel  input  1  port select, sampled with en: 0 = data port, 1 = status/control port.
- state  input  1  access direction, sampled with en: 1 = MCU read, 0 = MCU write.
- rd_data  input  16  word written by the MCU; valid when en=1 and state=0.
- wr_data  output  16  word returned to the MCU; driven continuously.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DEPTH words.

## Operation
- Storage: DEPTH×16 memory, write pointer wp, read pointer rp, and count cnt[CW-1:0]. Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Data write (en, sel=0, state=0):
  - If not full: mem[wp]←rd_data, wp+1, cnt+1.
  - If full: the word is dropped, pointers are unchanged, and ovf←1.
- Data read (en, sel=0, state=1):
  - If not empty: rp+1, cnt-1. The word returned is the head value already present on wr_data (show-ahead).
  - If empty: no pointer change, and unf←1.
- Status write (en, sel=1, state=0):
  - rd_data[0]=1 flushes: wp←0, rp←0, cnt←0.
  - rd_data[1]=1 clears ovf and unf.
  - Both bits may be set in one write; both actions take effect on the same edge.
  - Other bits are ignored.
- Status read (en, sel=1, state=1): no state change.
- wr_data mux:
  - sel=0: mem[rp] when not empty, 16'h0000 when empty.
  - sel=1: status word = {ovf, unf, full, empty, 1'b0 pad, cnt zero-extended to 11 bits}. Bit 15 = ovf, 14 = unf, 13 = full, 12 = empty, 11 = 0, 10:0 = cnt.
- empty = (cnt==0); full = (cnt==DEPTH). Both are combinational from registered cnt.
- en=0: no state change regardless of sel/state/rd_data.
- Memory contents are not reset; only pointers, count and flags are reset.

## Timing
- Reset values: wp=0, rp=0, cnt=0, ovf=0, unf=0, empty=1, full=0. wr_data=16'h0000 for sel=0, and 16'h1000 for sel=1.
- Push/pop/flush/clear take effect on the rising clk edge where en=1. Updated cnt, empty, full and head are visible on wr_data one clk after that edge.
- Push latency to readable head: a word pushed into an empty FIFO appears on wr_data (sel=0) 1 clk after the push edge.
- wr_data is combinational from registered state and sel. `fsmc_interface` latches it during NOE, and en for the next access never arrives within 1 clk of the previous one.
- Reset asserted mid-operation immediately clears all state, regardless of clk or en. Accesses during reset are ignored.
- Consecutive strobes on consecutive clks are legal and each is processed independently.

## Test plan
- Reset, then status read -> wr_data=16'h1000; data read -> 16'h0000 and unf then sets, so the status read gives 16'h5000.
- Write 0xA5A5, 0x1234, 0xFFFF to the data port -> status 16'h0003; three data reads return 0xA5A5, 0x1234, 0xFFFF in order, then status = 16'h1000.
- DEPTH=16: write 17 words 0x0000..0x0010 -> status 16'hA010 (ovf, full, cnt=16). Reads return 0x0000..0x000F; the 17th word is lost.
- Wrap-around: loop 40 times writing 3 words then reading 3 words with incrementing values -> every read matches the write order; final status 16'h1000.
- Write 5 words, cause an underflow beforehand, then status write 0x0003 -> the next status read is 16'h1000 and the next data read is 0x0000.
- Write 4 words, pulse reset_n low between clk edges -> empty=1 immediately, status 16'h1000 with no clk, and a subsequent write/read works normally.
